regs_wb_arbiter: RTL
====================

Name: regs_wb_arbiter

Overview:
Shares the single write port of the 32 x n general-purpose register file between two writeback requesters: A (ALU result path) and B (I/O / load-return path). Each requester has a one-entry holding slot behind a valid/ready handshake. The arbiter issues at most one register write per cycle, oldest first, with round-robin tie-break. Writes to %0 are consumed and discarded. Outputs drive the register file's w, write address and w_data inputs through the datapath write mux.

Parameters:
n, 8, data bus width; must equal the register file width.
CW, 8, width of the saturating conflict counter.

Ports:
clk  input  1  system clock, rising edge
n_reset  input  1  asynchronous active-low reset
a_valid  input  1  requester A presents a write
a_ready  output  1  A slot can accept this cycle
a_rd  input  5  A destination register
a_data  input  n  A write data
b_valid  input  1  requester B presents a write
b_ready  output  1  B slot can accept this cycle
b_rd  input  5  B destination register
b_data  input  n  B write data
w  output  1  register-file write enable (registered)
Rd  output  5  register-file write address (registered)
w_data  output  n  register-file write data (registered)
busy  output  1  any slot full or w high
conflicts  output  CW  count of cycles with both slots full, saturating

Behaviour:
- Reset (async, n_reset low): slots A/B empty, age bit 0, rr pointer = A, w=0, Rd=0, w_data=0, conflicts=0. Slot contents are discarded, and an in-flight w is cleared immediately. After release, the first accept is possible on the first rising edge.
- Slot state per requester: full flag, rd, data.
- Accept: on a rising edge with x_valid & x_ready, load the slot and set full.
- x_ready = !full_x | grant_x.
  - Combinational from registered state only; no path from valid.
  - A granted slot can refill on the same edge it drains.
- Grant (comb, from registered state):
  - Only one slot full: grant it.
  - Both full: grant the older one, per the age bit. The age bit records which slot was loaded strictly earlier.
  - Both loaded on the same edge (age tie): grant the rr pointer side, then toggle rr.
  - rr changes only on tie-breaks.
- Issue: on the edge after a grant, clear the granted slot (unless refilled on that edge) and load the output registers.
  - Granted rd != 0: w=1, Rd=rd, w_data=data for exactly one cycle.
  - Granted rd == 0: slot cleared, w=0; Rd/w_data hold their previous values.
  - No grant: w=0; Rd/w_data hold.
- Latency: accept edge k -> w high in cycle k+1..k+2 (issued at edge k+1) -> register-file write at edge k+2 if uncontested. Contested: +1 cycle per older/tie-winning write.
- Throughput: 1 write/cycle sustained. A single requester streaming every cycle sees ready held high.
- Ordering: the older of two pending writes always issues first. Same-edge writes to the same rd resolve by rr, so the later issue (last writer) is the non-rr side. Upstream must not depend on the order of same-edge writes to the same register.
- Age bit updates on every edge:
  - Exactly one slot is loaded while the other stays full: the staying slot becomes older.
  - Both loaded on the same edge: tie.
- conflicts increments on each edge where both slots were full, saturating at 2^CW-1. Cleared only by reset.
- busy = full_a | full_b | w.
- No X propagation: outputs are defined whenever n_reset is low or after the first edge.

Test Plan:
1. Reset then A: a_valid=1, a_rd=5, a_data=8'h3C for one cycle -> a_ready=1; w=1, Rd=5, w_data=8'h3C exactly one cycle later; busy low afterwards.
2. Both valid on the same edge (A: rd=3, 8'h11; B: rd=4, 8'h22) from reset -> w pulses for Rd=3 then Rd=4 on consecutive cycles; rr toggles to B; conflicts=1. Repeat -> B issues first.
3. Age ordering: B accepted (rd=7, 8'hAA), and one edge later A accepted while B is still pending -> B issues before A regardless of rr.
4. %0 discard: A writes rd=0, 8'hFF -> a_ready stays 1, w never asserts, Rd/w_data unchanged, slot empties next edge.
5. Streaming: A valid every cycle for 20 cycles with rd 1..20 (mod 32), B idle -> a_ready constantly 1; 20 consecutive w pulses in order; conflicts=0.
6. Mid-operation reset: both slots full and w=1, then n_reset low asynchronously mid-cycle -> w, Rd, w_data, conflicts go to 0 immediately; after release, no stale write issues. Also cover saturation: hold both full for 300 cycles with CW=8 -> conflicts=255.

Source files
------------

// File: rtl/regs_wb_arbiter.sv
// Writeback arbiter that shares the register-file write port between requester A
// (ALU results) and requester B (I/O and load returns). Each requester has a
// one-entry holding slot. The older write goes first, and writes loaded on the
// same edge are ordered round-robin. Writes to %0 are dropped.
module regs_wb_arbiter #(
  parameter int n  = 8,
  parameter int CW = 8
) (
  input  logic          clk,
  input  logic          n_reset,
  input  logic          a_valid,
  output logic          a_ready,
  input  logic [4:0]    a_rd,
  input  logic [n-1:0]  a_data,
  input  logic          b_valid,
  output logic          b_ready,
  input  logic [4:0]    b_rd,
  input  logic [n-1:0]  b_data,
  output logic          w,
  output logic [4:0]    Rd,
  output logic [n-1:0]  w_data,
  output logic          busy,
  output logic [CW-1:0] conflicts
);

  typedef enum logic {SIDE_A = 1'b0, SIDE_B = 1'b1} side_e;

  // Slot storage
  logic          full_a_q, full_a_d, full_b_q, full_b_d;
  logic [4:0]    rd_a_q, rd_a_d, rd_b_q, rd_b_d;
  logic [n-1:0]  data_a_q, data_a_d, data_b_q, data_b_d;
  // Ordering state: older_q is meaningful only when tie_q is clear
  side_e         older_q, older_d, rr_q, rr_d;
  logic          tie_q, tie_d;
  // Output registers
  logic          w_q, w_d;
  logic [4:0]    rd_q, rd_d;
  logic [n-1:0]  wdata_q, wdata_d;
  logic [CW-1:0] conflicts_q, conflicts_d;

  logic grant_a, grant_b, both_full, load_a, load_b;
  logic [4:0]   sel_rd;
  logic [n-1:0] sel_data;

  assign both_full = full_a_q & full_b_q;

  // Grant selection from registered state only, so ready never depends on valid
  always_comb begin
    // NOTE: every signal assigned here gets a default first so no latch is inferred.
    grant_a = 1'b0;
    grant_b = 1'b0;
    rr_d    = rr_q;
    if (both_full) begin
      if (tie_q) begin
        grant_a = (rr_q == SIDE_A);
        grant_b = (rr_q == SIDE_B);
        rr_d    = (rr_q == SIDE_A) ? SIDE_B : SIDE_A;
      end else begin
        grant_a = (older_q == SIDE_A);
        grant_b = (older_q == SIDE_B);
      end
    end else begin
      grant_a = full_a_q;
      grant_b = full_b_q;
    end
  end

  // A granted slot drains on the coming edge, so it may refill on that same edge
  assign a_ready = ~full_a_q | grant_a;
  assign b_ready = ~full_b_q | grant_b;
  assign load_a  = a_valid & a_ready;
  assign load_b  = b_valid & b_ready;

  // Slot next state, age tracking and issue selection
  always_comb begin
    full_a_d = load_a | (full_a_q & ~grant_a);
    full_b_d = load_b | (full_b_q & ~grant_b);
    rd_a_d   = load_a ? a_rd   : rd_a_q;
    data_a_d = load_a ? a_data : data_a_q;
    rd_b_d   = load_b ? b_rd   : rd_b_q;
    data_b_d = load_b ? b_data : data_b_q;

    // A slot that stays full while the other one loads becomes the older one
    older_d = older_q;
    tie_d   = tie_q;
    if (load_a && load_b) begin
      tie_d = 1'b1;
    end else if (load_a && full_b_q && !grant_b) begin
      older_d = SIDE_B;
      tie_d   = 1'b0;
    end else if (load_b && full_a_q && !grant_a) begin
      older_d = SIDE_A;
      tie_d   = 1'b0;
    end

    sel_rd   = grant_a ? rd_a_q   : rd_b_q;
    sel_data = grant_a ? data_a_q : data_b_q;

    // A granted write to %0 empties its slot without pulsing w
    w_d     = (grant_a | grant_b) && (sel_rd != 5'd0);
    rd_d    = w_d ? sel_rd   : rd_q;
    wdata_d = w_d ? sel_data : wdata_q;

    conflicts_d = conflicts_q;
    if (both_full && (conflicts_q != {CW{1'b1}}))
      conflicts_d = conflicts_q + CW'(1);
  end

  // State registers; reset also clears an in-flight write immediately
  always_ff @(posedge clk or negedge n_reset) begin
    // NOTE: slot payloads are reset as well, so no X can reach w_data even though full gates them.
    if (!n_reset) begin
      full_a_q    <= 1'b0;
      full_b_q    <= 1'b0;
      rd_a_q      <= '0;
      rd_b_q      <= '0;
      data_a_q    <= '0;
      data_b_q    <= '0;
      older_q     <= SIDE_A;
      tie_q       <= 1'b0;
      rr_q        <= SIDE_A;
      w_q         <= 1'b0;
      rd_q        <= '0;
      wdata_q     <= '0;
      conflicts_q <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the pre-edge state.
      full_a_q    <= full_a_d;
      full_b_q    <= full_b_d;
      rd_a_q      <= rd_a_d;
      rd_b_q      <= rd_b_d;
      data_a_q    <= data_a_d;
      data_b_q    <= data_b_d;
      older_q     <= older_d;
      tie_q       <= tie_d;
      rr_q        <= rr_d;
      w_q         <= w_d;
      rd_q        <= rd_d;
      wdata_q     <= wdata_d;
      conflicts_q <= conflicts_d;
    end
  end

  assign w         = w_q;
  assign Rd        = rd_q;
  assign w_data    = wdata_q;
  assign conflicts = conflicts_q;
  assign busy      = full_a_q | full_b_q | w_q;

endmodule
